uart_rx: RTL and testbench

UART receiver. It is the receive-side counterpart of the UART TX sync FIFO path.
- Oversamples an asynchronous serial line and detects start bits.
- Samples each data bit at mid-bit and checks the stop bit.
- Presents each received byte on a valid/ready interface with a one-entry holding register.
- Typically drives the write side of an RX sync FIFO (rx_valid -> wr_en, rx_ready <- !full).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_rx_state_e           receiver FSM state encoding
//   CLKS_PER_BIT_DEFAULT      default oversampling ratio (clk cycles per bit)
//   UART_IDLE_LEVEL           line level while no frame is in flight
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam int   CLKS_PER_BIT_DEFAULT = 16;
  localparam logic UART_IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (both flops load RESET_VAL)
//   d      in  asynchronous input
//   q      out d delayed by two clk cycles, safe to use in the clk domain
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry holding register.
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   rx           in  serial line, asynchronous to clk, idle high
//   rx_data      out received byte, stable while rx_valid=1
//   rx_valid     out holding register full
//   rx_ready     in  consumer accepts when rx_valid && rx_ready
//   frame_err    out 1-cycle pulse: stop bit sampled low
//   overrun_err  out 1-cycle pulse: completed byte dropped (holding register full)
//   parity_err   out 1-cycle pulse: even-parity mismatch (only with UART_RX_PARITY_EN)
//   busy         out receiver is inside a frame
// Build option: define UART_RX_PARITY_EN to add an even parity bit between
// the data bits and the stop bit, plus the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_rx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_err_q, overrun_err_d;
  logic                  busy_q, busy_d;
  logic                  rx_s;        // synchronized line
  logic                  rx_prev_q;   // rx_s one cycle earlier, for falling-edge detect
  logic                  done_ok_s;   // stop bit sampled high this cycle
  logic                  done_bad_s;  // stop bit sampled low this cycle
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  parity_err_q, parity_err_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_bad(input logic [DATA_WIDTH-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction
`endif

  uart_sync_2ff #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // State register: every flop of the receiver, async reset to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      idx_q         <= IDX_ZERO;
      sh_q          <= {DATA_WIDTH{1'b0}};
      rx_prev_q     <= UART_IDLE_LEVEL;
      rx_data_q     <= {DATA_WIDTH{1'b0}};
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      rx_prev_q     <= rx_s;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and frame sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    done_ok_s  = 1'b0;
    done_bad_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a stuck-low line does not.
        if (!rx_s && rx_prev_q) begin
          state_d = START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Re-check the start bit at its middle to reject glitches.
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          if (rx_s == 1'b0) begin
            state_d = DATA;
            idx_d   = IDX_ZERO;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          sh_d  = {rx_s, sh_q[DATA_WIDTH-1:1]};  // LSB arrives first
          cnt_d = CNT_ZERO;
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_LAST) begin
          par_d   = rx_s;
          cnt_d   = CNT_ZERO;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
`endif
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = CNT_ZERO;
          state_d    = IDLE;
          done_ok_s  = rx_s;
          done_bad_s = ~rx_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // Output logic: holding register handshake and single-cycle error pulses.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = done_bad_s;
    overrun_err_d = 1'b0;
    busy_d        = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    parity_err_d  = done_ok_s & even_parity_bad(sh_q, par_q);
`endif
    if (done_ok_s) begin
      // A consume on the same edge frees the register for the new byte.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (DATA_WIDTH=8, CLKS_PER_BIT=16).
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Drive of start bit at a negedge -> 2 sync edges + 1 detect edge, then
  // half a bit plus the data (and parity) and stop bit periods.
  localparam int RISE = 3 + CPB / 2 + CPB * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and rising-edge monitors, sampled away from the active edge.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun_err) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    if (rx_valid && !prev_valid) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    idle(2);
  endtask

  // Drive one frame; optionally pulse rx_ready on the completion edge or abort at slot cycle abort_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic ready_pulse, input int abort_at);
    logic [10:0] bits;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[9]  = par_b;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
    if (par_b) bits[10] = 1'b1;
`endif
    for (int j = 0; j < NBITS * CPB; j++) begin
      @(negedge clk);
      if (j == abort_at) begin
        rx = 1'b1;
        return;
      end
      rx = bits[j / CPB];
      if (j == 0) start_cyc = cyc;
      if (ready_pulse && j == RISE - 1) rx_ready = 1'b1;
      if (ready_pulse && j == RISE) rx_ready = 1'b0;
    end
    @(negedge clk) rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", frame_err, overrun_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_clean();
    int fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, -1);
    idle(4);
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL clean_data got=%h exp=a5", rx_data); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL clean_valid got=%b exp=1", rx_valid); end
    total++; if (rise_cyc !== start_cyc + RISE) begin bad++; $display("FAIL clean_latency got=%0d exp=%0d", rise_cyc - start_cyc, RISE); end
    total++; if (fe_cnt !== fe0 || ov_cnt !== ov0 || pe_cnt !== pe0) begin bad++; $display("FAIL clean_flags got=%0d/%0d/%0d exp=0/0/0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0); end
    drain();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL clean_consume got=%b exp=0", rx_valid); end
  endtask

  task automatic test_glitch();
    int fe0, ov0, rc0;
    fe0 = fe_cnt; ov0 = ov_cnt; rc0 = rise_cnt;
    @(negedge clk) rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
    idle(7);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
    idle(30);
    total++; if (rise_cnt !== rc0 || rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
    total++; if (fe_cnt !== fe0 || ov_cnt !== ov0) begin bad++; $display("FAIL glitch_flags got=%0d/%0d exp=0/0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_framing();
    int fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    // Parity bit deliberately wrong: a bad stop bit must suppress parity_err.
    send_frame(8'h3C, 1'b0, ~(^8'h3C), 1'b0, -1);
    idle(20);
    total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL frame_pulse got=%0d exp=1", fe_cnt - fe0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL frame_valid got=%b exp=0", rx_valid); end
    total++; if (ov_cnt !== ov0 || pe_cnt !== pe0) begin bad++; $display("FAIL frame_other got=%0d/%0d exp=0/0", ov_cnt - ov0, pe_cnt - pe0); end
  endtask

  task automatic test_back_to_back();
    int ov0, rc0;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, -1);
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, -1);
    idle(4);
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL overrun_data got=%h exp=3c", rx_data); end
    total++; if (ov_cnt !== ov0 + 1) begin bad++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt - ov0); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b exp=1", rx_valid); end
    drain();
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, -1);
    rc0 = rise_cnt;
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b1, -1);
    idle(4);
    total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL b2b_data got=%h exp=c3", rx_data); end
    total++; if (rx_valid !== 1'b1 || rise_cnt !== rc0) begin bad++; $display("FAIL b2b_valid got=%b rises=%0d exp=1 rises=0", rx_valid, rise_cnt - rc0); end
    total++; if (ov_cnt !== ov0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid();
    // Holding register still full from the previous test; abort 0x55 during bit 3.
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0, 70);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_out got=%h/%b exp=00/0", rx_data, rx_valid); end
    total++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b%b exp=000", busy, frame_err, overrun_err); end
    idle(2);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0, -1);
    idle(4);
    total++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin bad++; $display("FAIL midrst_next got=%h/%b exp=81/1", rx_data, rx_valid); end
    drain();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
    idle(4);
    total++; if (rx_data !== 8'h07 || rx_valid !== 1'b1) begin bad++; $display("FAIL par_bad_data got=%h/%b exp=07/1", rx_data, rx_valid); end
    total++; if (pe_cnt !== pe0 + 1) begin bad++; $display("FAIL par_bad_pulse got=%0d exp=1", pe_cnt - pe0); end
    drain();
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
    idle(4);
    total++; if (rx_data !== 8'h07 || rx_valid !== 1'b1) begin bad++; $display("FAIL par_ok_data got=%h/%b exp=07/1", rx_data, rx_valid); end
    total++; if (pe_cnt !== pe0) begin bad++; $display("FAIL par_ok_pulse got=%0d exp=0", pe_cnt - pe0); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
